// File: rtl/wfg_record_spi.sv
// SPI target for the stimulus loopback path: oversamples sclk/cs_n/sdi in the
// wb_clk_i domain, deserializes 8/16/24/32-bit words and offers them on AXI-Stream.
module wfg_record_spi #(
    parameter int SYNC_STAGES = 2,
    parameter int AXIS_W      = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              cfg_en_i,
    input  logic              cfg_cpol_i,
    input  logic              cfg_cpha_i,
    input  logic              cfg_lsbfirst_i,
    input  logic [1:0]        cfg_dff_i,
    input  logic              cfg_clr_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_ni,
    input  logic              spi_sdi_i,
    input  logic              wfg_axis_tready_i,
    output logic              wfg_axis_tvalid_o,
    output logic [AXIS_W-1:0] wfg_axis_tdata_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              frame_err_o
);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
    logic                   sclk_prev_q, rise_q, fall_q, sdi_q, cs_n_q;

    state_t              state_q;
    logic [4:0]          bit_cnt_q;
    logic [AXIS_W-1:0]   shift_q;
    logic                cpol_q, cpha_q, lsbfirst_q;
    logic [1:0]          dff_q;
    logic [AXIS_W-1:0]   word_q;
    logic                word_done_q;
    logic                frame_err_q;

    logic                tvalid_q;
    logic [AXIS_W-1:0]   tdata_q;
    logic                overflow_q;

    logic                sample_d;
    logic                last_bit_d;
    logic [4:0]          bit_cnt_d;
    logic [AXIS_W-1:0]   shift_d;
    logic [AXIS_W-1:0]   len_mask_d;
    logic [AXIS_W-1:0]   word_d;

    // Pin synchronizers plus one edge-detect stage; sdi and cs_n ride the same
    // depth as sclk so data and framing stay aligned with the detected edge.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sclk_sync_q <= '0;
            // NOTE: chip select resets to its inactive level so reset never looks like a frame start.
            cs_sync_q   <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            sdi_q       <= 1'b0;
            cs_n_q      <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            rise_q      <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
            fall_q      <= ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
            sdi_q       <= sdi_sync_q[SYNC_STAGES-1];
            cs_n_q      <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    // The sample edge is the rising edge when cpol==cpha, the falling edge otherwise.
    always_comb begin
        sample_d   = (rise_q & ~(cpol_q ^ cpha_q)) | (fall_q & (cpol_q ^ cpha_q));
        last_bit_d = (bit_cnt_q == {dff_q, 3'b111});
        len_mask_d = {AXIS_W{1'b1}} >> {~dff_q, 3'b000};
        if (lsbfirst_q) begin
            shift_d = shift_q | (AXIS_W'(sdi_q) << bit_cnt_q);
        end else begin
            shift_d = {shift_q[AXIS_W-2:0], sdi_q};
        end
        word_d    = shift_d & len_mask_d;
        bit_cnt_d = bit_cnt_q;
        if (sample_d) begin
            bit_cnt_d = last_bit_d ? 5'd0 : bit_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfirst_q  <= 1'b0;
            dff_q       <= 2'b00;
            word_q      <= '0;
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_en_i && !cs_n_q) begin
                        state_q    <= ST_SHIFT;
                        bit_cnt_q  <= '0;
                        shift_q    <= '0;
                        cpol_q     <= cfg_cpol_i;
                        cpha_q     <= cfg_cpha_i;
                        lsbfirst_q <= cfg_lsbfirst_i;
                        dff_q      <= cfg_dff_i;
                    end
                end
                ST_SHIFT: begin
                    if (!cfg_en_i) begin
                        state_q   <= ST_IDLE;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end else begin
                        if (sample_d) begin
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit_d) begin
                                word_q      <= word_d;
                                word_done_q <= 1'b1;
                                shift_q     <= '0;
                            end else begin
                                shift_q <= shift_d;
                            end
                        end
                        // A sample edge seen together with CS release is counted first.
                        if (cs_n_q) begin
                            state_q     <= ST_IDLE;
                            frame_err_q <= (bit_cnt_d != 5'd0);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Single-entry output register; a completing word may replace one being handed off.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (word_done_q) begin
                if (!tvalid_q || wfg_axis_tready_i) begin
                    tdata_q  <= word_q;
                    tvalid_q <= 1'b1;
                end
            end else if (tvalid_q && wfg_axis_tready_i) begin
                tvalid_q <= 1'b0;
            end

            if (word_done_q && tvalid_q && !wfg_axis_tready_i) begin
                overflow_q <= 1'b1;
            end else if (cfg_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign wfg_axis_tvalid_o = tvalid_q;
    assign wfg_axis_tdata_o  = tdata_q;
    assign busy_o            = (state_q == ST_SHIFT);
    assign overflow_o        = overflow_q;
    assign frame_err_o       = frame_err_q;

endmodule

// File: tb/tb_wfg_record_spi.sv
// Self-checking bench for wfg_record_spi: a behavioural SPI master drives the pins
// and a queue of expected words is compared against every accepted stream beat.
`timescale 1ns/1ps
module tb_wfg_record_spi;

    localparam int S    = 2;
    localparam int HALF = 40;

    logic        clk;
    logic        rst_n;
    logic        cfg_en, cfg_cpol, cfg_cpha, cfg_lsb, cfg_clr;
    logic [1:0]  cfg_dff;
    logic        sclk, cs_n, sdi;
    logic        tready, tvalid;
    logic [31:0] tdata;
    logic        busy, ovf, ferr;

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int          beats = 0;
    int          ferr_cycles = 0;
    logic [31:0] exp_q[$];
    logic [31:0] tx_words[4];

    wfg_record_spi #(.SYNC_STAGES(S), .AXIS_W(32)) dut (
        .wb_clk_i          (clk),
        .wb_rst_ni         (rst_n),
        .cfg_en_i          (cfg_en),
        .cfg_cpol_i        (cfg_cpol),
        .cfg_cpha_i        (cfg_cpha),
        .cfg_lsbfirst_i    (cfg_lsb),
        .cfg_dff_i         (cfg_dff),
        .cfg_clr_i         (cfg_clr),
        .spi_sclk_i        (sclk),
        .spi_cs_ni         (cs_n),
        .spi_sdi_i         (sdi),
        .wfg_axis_tready_i (tready),
        .wfg_axis_tvalid_o (tvalid),
        .wfg_axis_tdata_o  (tdata),
        .busy_o            (busy),
        .overflow_o        (ovf),
        .frame_err_o       (ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beat scoreboard, sampled mid-cycle; tready only changes just after a rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tvalid === 1'b1 && tready === 1'b1) begin
            beats++;
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("beat_tdata", tdata, exp_q.pop_front());
        end
        if (ferr === 1'b1) ferr_cycles++;
    end

    // Reference: each word is its low len bits; a stalled sink keeps only the first.
    task automatic model_push(input int nwords, input logic [1:0] dff, input bit ready);
        int          len;
        logic [31:0] mask;
        len  = 8 * (int'(dff) + 1);
        mask = (len == 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
        for (int w = 0; w < nwords; w++) begin
            if (ready || w == 0) exp_q.push_back(tx_words[w] & mask);
        end
    endtask

    task automatic measure_latency();
        int cnt;
        bit got;
        cnt = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (tvalid === 1'b1) got = 1;
        end
        chk("latency_cycles", cnt, S + 3);
        chk("busy_in_frame", busy, 1);
    endtask

    task automatic spi_send(input logic cpol, input logic cpha, input logic lsb,
                            input logic [1:0] dff, input int nwords, input int cut_bits,
                            input bit keep_cs, input bit measure);
        int   len;
        int   sent;
        bit   stop;
        logic b;
        len      = 8 * (int'(dff) + 1);
        cfg_cpol = cpol;
        cfg_cpha = cpha;
        cfg_lsb  = lsb;
        cfg_dff  = dff;
        sclk     = cpol;
        sdi      = 1'b0;
        @(posedge clk);
        #3;
        #(HALF) cs_n = 1'b0;
        #(HALF);
        sent = 0;
        stop = 0;
        for (int w = 0; w < nwords && !stop; w++) begin
            for (int i = 0; i < len && !stop; i++) begin
                b = lsb ? tx_words[w][i] : tx_words[w][len-1-i];
                if (!cpha) begin
                    sdi = b;
                    #(HALF) sclk = ~cpol;
                    if (measure && w == nwords - 1 && i == len - 1) measure_latency();
                    #(HALF) sclk = cpol;
                end else begin
                    sclk = ~cpol;
                    sdi  = b;
                    #(HALF) sclk = cpol;
                    if (measure && w == nwords - 1 && i == len - 1) measure_latency();
                    #(HALF);
                end
                sent++;
                // Configuration changes mid-frame must not affect the receiver.
                if (sent == 1) begin
                    cfg_cpol = 1'($urandom);
                    cfg_cpha = 1'($urandom);
                    cfg_lsb  = 1'($urandom);
                    cfg_dff  = 2'($urandom);
                end
                if (cut_bits > 0 && sent == cut_bits) stop = 1;
            end
        end
        if (!keep_cs) begin
            #(HALF) cs_n = 1'b1;
            repeat (12) @(posedge clk);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "timeout");
    end

    initial begin
        int   b0, f0;
        logic rc_cpol, rc_cpha, rc_lsb;
        logic [1:0] rc_dff;
        int   rc_n;

        rst_n = 1'b0;  cfg_en = 1'b1;  cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        cfg_lsb = 1'b0; cfg_dff = 2'b00; cfg_clr = 1'b0;
        sclk = 1'b0;   cs_n = 1'b1;    sdi = 1'b0;      tready = 1'b1;
        #22;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_ferr", ferr, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Mode 0, MSB-first, 8-bit, with latency measurement
        tx_words[0] = 32'hA5;
        model_push(1, 2'b00, 1);
        b0 = beats; f0 = ferr_cycles;
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 0, 0, 1);
        chk("t1_beats", beats - b0, 1);
        chk("t1_ovf", ovf, 0);
        chk("t1_ferr", ferr_cycles - f0, 0);
        chk("t1_busy_after", busy, 0);
        chk("t1_drained", exp_q.size(), 0);

        // Mode 3 LSB-first 32-bit, then modes 1 and 2 with 16-bit words
        tx_words[0] = 32'h1234_5678;
        model_push(1, 2'b11, 1);
        spi_send(1'b1, 1'b1, 1'b1, 2'b11, 1, 0, 0, 0);
        chk("t2_m3_drained", exp_q.size(), 0);
        tx_words[0] = 32'hBEEF;
        model_push(1, 2'b01, 1);
        spi_send(1'b0, 1'b1, 1'b0, 2'b01, 1, 0, 0, 0);
        chk("t2_m1_drained", exp_q.size(), 0);
        model_push(1, 2'b01, 1);
        spi_send(1'b1, 1'b0, 1'b1, 2'b01, 1, 0, 0, 0);
        chk("t2_m2_drained", exp_q.size(), 0);

        // Back-to-back 16-bit words into a stalled sink
        @(posedge clk); #2 tready = 1'b0;
        tx_words[0] = 32'h1111; tx_words[1] = 32'h2222; tx_words[2] = 32'h3333;
        model_push(3, 2'b01, 0);
        spi_send(1'b0, 1'b0, 1'b0, 2'b01, 3, 0, 0, 0);
        chk("t3_tvalid", tvalid, 1);
        chk("t3_tdata_held", tdata, exp_q[0]);
        chk("t3_ovf_set", ovf, 32'(3 > 1));
        @(posedge clk); #2 cfg_clr = 1'b1;
        @(posedge clk); #2 cfg_clr = 1'b0;
        chk("t3_ovf_cleared", ovf, 0);
        chk("t3_tdata_stable", tdata, exp_q[0]);
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("t3_drained", exp_q.size(), 0);
        chk("t3_tvalid_low", tvalid, 0);

        // 24-bit back-to-back with an always-ready sink
        tx_words[0] = 32'hABCDEF; tx_words[1] = 32'h123456;
        model_push(2, 2'b10, 1);
        b0 = beats;
        spi_send(1'b0, 1'b0, 1'b0, 2'b10, 2, 0, 0, 0);
        chk("t4_beats", beats - b0, 2);
        chk("t4_ovf", ovf, 0);
        chk("t4_drained", exp_q.size(), 0);

        // CS released after 5 bits, then a clean frame
        tx_words[0] = 32'($urandom_range(0, 255));
        b0 = beats; f0 = ferr_cycles;
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 5, 0, 0);
        chk("t5_ferr_pulse", ferr_cycles - f0, 1);
        chk("t5_no_beat", beats - b0, 0);
        tx_words[0] = 32'h3C;
        model_push(1, 2'b00, 1);
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 0, 0, 0);
        chk("t5_drained", exp_q.size(), 0);

        // Async reset mid-frame while a word is held
        @(posedge clk); #2 tready = 1'b0;
        tx_words[0] = 32'($urandom_range(0, 255));
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 0, 0, 0);
        chk("t6_held_tvalid", tvalid, 1);
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 4, 1, 0);
        chk("t6_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_tdata", tdata, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", ovf, 0);
        chk("t6_rst_ferr", ferr, 0);
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        tready = 1'b1;
        tx_words[0] = 32'h5A;
        model_push(1, 2'b00, 1);
        spi_send(1'b0, 1'b0, 1'b0, 2'b00, 1, 0, 0, 0);
        chk("t6_after_rst_drained", exp_q.size(), 0);

        // Randomized modes, orders, lengths and word counts
        for (int r = 0; r < 6; r++) begin
            rc_cpol = 1'($urandom);
            rc_cpha = 1'($urandom);
            rc_lsb  = 1'($urandom);
            rc_dff  = 2'($urandom);
            rc_n    = int'($urandom_range(1, 3));
            for (int w = 0; w < rc_n; w++) tx_words[w] = $urandom;
            model_push(rc_n, rc_dff, 1);
            spi_send(rc_cpol, rc_cpha, rc_lsb, rc_dff, rc_n, 0, 0, 0);
            chk("rand_drained", exp_q.size(), 0);
            chk("rand_ovf", ovf, 0);
        end

        repeat (10) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
